wash_cycle_controller: RTL

Sequencing FSM for the washing-machine controller. It accepts a coin, then steps the drum through fill, wash, rinse and spin phases, holding each for a duration scaled by the selected system clock frequency. It supports an optional double-wash pass and a spin-phase pause. It drives the phase code consumed by the duration and actuator logic, and signals cycle completion.

---
 rtl/wash_cycle_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/wash_cycle_controller.sv
// Washing-machine cycle sequencer: coin start, then FILL/WASH/RINSE/SPIN phases
// with durations scaled by the selected clock frequency, optional second
// wash+rinse pass, SPIN-only pause, and a one-cycle completion pulse.
module wash_cycle_controller #(
  parameter int unsigned FILL_UNITS       = 120,
  parameter int unsigned WASH_UNITS       = 300,
  parameter int unsigned RINSE_UNITS      = 120,
  parameter int unsigned SPIN_UNITS       = 60,
  parameter int unsigned UNIT_CYCLES_1MHZ = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  clock_frequency,
  input  logic        coin_in,
  input  logic        double_wash,
  input  logic        timer_pause,
  output logic [2:0]  state,
  output logic        busy,
  output logic [31:0] phase_remaining,
  output logic        wash_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_FILL  = 3'b001,
    ST_WASH  = 3'b010,
    ST_RINSE = 3'b011,
    ST_SPIN  = 3'b100
  } state_t;

  // Phase lengths at 1 MHz; the frequency multiplier is applied as a left shift.
  localparam logic [31:0] FILL_BASE  = 32'(FILL_UNITS  * UNIT_CYCLES_1MHZ);
  localparam logic [31:0] WASH_BASE  = 32'(WASH_UNITS  * UNIT_CYCLES_1MHZ);
  localparam logic [31:0] RINSE_BASE = 32'(RINSE_UNITS * UNIT_CYCLES_1MHZ);
  localparam logic [31:0] SPIN_BASE  = 32'(SPIN_UNITS  * UNIT_CYCLES_1MHZ);

  state_t      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [1:0]  shift_q, shift_d;     // log2 of latched multiplier M
  logic        dw_q, dw_d;           // latched double_wash
  logic        second_q, second_d;   // second wash+rinse pass in progress
  logic        done_q, done_d;

  logic        freq_ok;
  logic [1:0]  freq_shift;
  logic        paused;

  function automatic logic [31:0] phase_len(input state_t ph, input logic [1:0] sh);
    logic [31:0] base;
    case (ph)
      ST_FILL:  base = FILL_BASE;
      ST_WASH:  base = WASH_BASE;
      ST_RINSE: base = RINSE_BASE;
      ST_SPIN:  base = SPIN_BASE;
      default:  base = 32'd0;
    endcase
    return base << sh;
  endfunction

  // Decode the one-hot frequency select into a shift amount and a validity flag.
  always_comb begin
    freq_ok    = 1'b1;
    freq_shift = 2'd0;
    case (clock_frequency)
      4'b0001: freq_shift = 2'd0;
      4'b0010: freq_shift = 2'd1;
      4'b0100: freq_shift = 2'd2;
      4'b1000: freq_shift = 2'd3;
      default: freq_ok    = 1'b0;
    endcase
  end

  // Next-state logic: start on a valid coin, count phases down, advance at zero.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    shift_d  = shift_q;
    dw_d     = dw_q;
    second_d = second_q;
    done_d   = 1'b0;
    paused   = (state_q == ST_SPIN) && timer_pause;
    case (state_q)
      ST_IDLE: begin
        rem_d = 32'd0;
        if (coin_in && freq_ok) begin
          state_d = ST_FILL;
          shift_d = freq_shift;
          dw_d    = double_wash;
          rem_d   = phase_len(ST_FILL, freq_shift) - 32'd1;
        end
      end
      ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
        if (!paused) begin
          if (rem_q != 32'd0) begin
            rem_d = rem_q - 32'd1;
          end else begin
            case (state_q)
              ST_FILL: begin
                state_d = ST_WASH;
                rem_d   = phase_len(ST_WASH, shift_q) - 32'd1;
              end
              ST_WASH: begin
                state_d = ST_RINSE;
                rem_d   = phase_len(ST_RINSE, shift_q) - 32'd1;
              end
              ST_RINSE: begin
                if (dw_q && !second_q) begin
                  state_d  = ST_WASH;
                  second_d = 1'b1;
                  rem_d    = phase_len(ST_WASH, shift_q) - 32'd1;
                end else begin
                  state_d = ST_SPIN;
                  rem_d   = phase_len(ST_SPIN, shift_q) - 32'd1;
                end
              end
              default: begin
                state_d  = ST_IDLE;
                rem_d    = 32'd0;
                second_d = 1'b0;
                done_d   = 1'b1;
              end
            endcase
          end
        end
      end
      default: begin
        // Unreachable encodings recover to IDLE.
        state_d  = ST_IDLE;
        rem_d    = 32'd0;
        second_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any cycle without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= 32'd0;
      shift_q  <= 2'd0;
      dw_q     <= 1'b0;
      second_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      shift_q  <= shift_d;
      dw_q     <= dw_d;
      second_q <= second_d;
      done_q   <= done_d;
    end
  end

  assign state           = state_q;
  assign busy            = (state_q != ST_IDLE);
  assign phase_remaining = rem_q;
  assign wash_done       = done_q;

endmodule
